// File: rtl/regfile_arbiter.sv
// Two-requester access controller for the 64 x 32 register file: arbitrates A/B, sequences
// IDLE -> ACCESS -> RESP, returns read data with a one-cycle ack. Macro: REGFILE_ARB_RR_EN.
module regfile_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,

    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [ADDR_W-1:0] rf_rs,
    output logic [ADDR_W-1:0] rf_rt,
    output logic [DATA_W-1:0] rf_writein,
    input  logic [DATA_W-1:0] rf_rsout,

    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              grant;
    logic              grant_sel;

    logic              cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;

    // Owner of the access in flight; with round-robin enabled it also serves as `last`.
    logic              winner_q;

    logic              a_ack_q, b_ack_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    logic              resp_a, resp_b;

    // Arbitration
    always_comb begin
        grant     = (state_q == IDLE) && (a_req || b_req);
        grant_sel = SEL_A;
`ifdef REGFILE_ARB_RR_EN
        if (a_req && b_req) begin
            grant_sel = (winner_q == SEL_B) ? SEL_A : SEL_B;
        end else if (b_req) begin
            grant_sel = SEL_B;
        end
`else
        if (b_req && !a_req) begin
            grant_sel = SEL_B;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command register: request fields are sampled only at the grant edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            winner_q    <= SEL_B;
        end else if (grant) begin
            winner_q <= grant_sel;
            if (grant_sel == SEL_B) begin
                cmd_we_q    <= b_we;
                cmd_addr_q  <= b_addr;
                cmd_wdata_q <= b_wdata;
            end else begin
                cmd_we_q    <= a_we;
                cmd_addr_q  <= a_addr;
                cmd_wdata_q <= a_wdata;
            end
        end
    end

    // Response: ack and read data land together at the RESP closing edge.
    always_comb begin
        resp_a = (state_q == RESP) && (winner_q == SEL_A);
        resp_b = (state_q == RESP) && (winner_q == SEL_B);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_ack_q <= resp_a;
            b_ack_q <= resp_b;
            if (resp_a && !cmd_we_q) begin
                a_rdata_q <= rf_rsout;
            end
            if (resp_b && !cmd_we_q) begin
                b_rdata_q <= rf_rsout;
            end
        end
    end

    // Addresses and write data hold between accesses; only the write strobe is gated.
    always_comb begin
        rf_write   = (state_q == ACCESS) && cmd_we_q;
        rf_rd      = cmd_addr_q;
        rf_rs      = cmd_addr_q;
        rf_rt      = cmd_addr_q;
        rf_writein = cmd_wdata_q;
        busy       = (state_q == ACCESS) || (state_q == RESP);
        a_ack      = a_ack_q;
        b_ack      = b_ack_q;
        a_rdata    = a_rdata_q;
        b_rdata    = b_rdata_q;
    end

endmodule
